// File: rtl/msk_g4mul_hpc1_pipe_pkg.sv
// Shared constants and helpers for the masked G(4) multiplier pipeline:
// randomness budget per lane, rnd word layout and the unmasked GF(2^2) product.
package msk_g4mul_hpc1_pipe_pkg;

    // Two register stages from operand acceptance to result.
    localparam int STAGES = 2;

    typedef logic [1:0] gf4_t;

    // Fresh bits per operand bit for the pairwise refresh of b.
    function automatic int ref_rnd(input int d);
        return d * (d - 1) / 2;
    endfunction

    // Fresh bits per product bit for the DOM cross-domain terms.
    function automatic int dom_rnd(input int d);
        return d * (d - 1) / 2;
    endfunction

    // Rnd bits per lane: REF part first, DOM part above it.
    function automatic int rnd_bits(input int d);
        return 2 * ref_rnd(d) + 2 * dom_rnd(d);
    endfunction

    function automatic int dom_off(input int d);
        return 2 * ref_rnd(d);
    endfunction

    // Linear index of share pair (i, j) with i < j, row-major over the upper triangle.
    function automatic int pair_idx(input int i, input int j, input int d);
        return i * d - i * (i + 1) / 2 + (j - i - 1);
    endfunction

    // GF(2^2) multiply in Canright normal basis; bilinear, so it distributes over shares.
    function automatic gf4_t gf4_mul(input gf4_t a, input gf4_t b);
        logic e;
        e = (a[1] ^ a[0]) & (b[1] ^ b[0]);
        return {(a[1] & b[1]) ^ e, (a[0] & b[0]) ^ e};
    endfunction

endpackage

// File: rtl/msk_g4mul_hpc1_pipe_lane.sv
// One lane: stage 1 registers a and the (optionally refreshed) b shares,
// stage 2 registers every DOM share-product term; outputs compress the terms.
module msk_g4mul_lane
    import msk_g4mul_hpc1_pipe_pkg::*;
#(
    parameter int D       = 2,
    parameter int REFRESH = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [D-1:0]           a0,
    input  logic [D-1:0]           a1,
    input  logic [D-1:0]           b0,
    input  logic [D-1:0]           b1,
    input  logic [rnd_bits(D)-1:0] rnd,
    output logic [D-1:0]           out0,
    output logic [D-1:0]           out1
);

    localparam int DOM = dom_off(D);

    logic [D-1:0][1:0]        b_ref;
    logic [D-1:0][1:0]        a_s1;
    logic [D-1:0][1:0]        b_s1;
    logic [D-1:0][D-1:0][1:0] term_d;
    logic [D-1:0][D-1:0][1:0] term_q;

    // Pairwise refresh of b: each pair's random lands on both shares, so the sum is unchanged.
    always_comb begin
        for (int i = 0; i < D; i++) begin
            b_ref[i] = {b1[i], b0[i]};
            if (REFRESH != 0) begin
                for (int j = 0; j < D; j++) begin
                    if (j < i)
                        b_ref[i] = b_ref[i] ^ rnd[2*pair_idx(j, i, D) +: 2];
                    else if (j > i)
                        b_ref[i] = b_ref[i] ^ rnd[2*pair_idx(i, j, D) +: 2];
                end
            end
        end
    end

    // DOM-indep terms: inner-domain products plain, cross-domain pairs blinded by a shared random.
    always_comb begin
        for (int i = 0; i < D; i++) begin
            for (int j = 0; j < D; j++) begin
                term_d[i][j] = gf4_mul(a_s1[i], b_s1[j]);
                if (i < j)
                    term_d[i][j] = term_d[i][j] ^ rnd[DOM + 2*pair_idx(i, j, D) +: 2];
                else if (j < i)
                    term_d[i][j] = term_d[i][j] ^ rnd[DOM + 2*pair_idx(j, i, D) +: 2];
            end
        end
    end

    // Share registers: both stages advance together on en and clear on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_s1   <= '0;
            b_s1   <= '0;
            term_q <= '0;
        end else if (en) begin
            for (int i = 0; i < D; i++)
                a_s1[i] <= {a1[i], a0[i]};
            b_s1   <= b_ref;
            term_q <= term_d;
        end
    end

    // Compression: output share i is the XOR of its registered row of terms.
    always_comb begin : compress
        gf4_t acc;
        for (int i = 0; i < D; i++) begin
            acc = '0;
            for (int j = 0; j < D; j++)
                acc = acc ^ term_q[i][j];
            out1[i] = acc[1];
            out0[i] = acc[0];
        end
    end

endmodule

// File: rtl/msk_g4mul_hpc1_pipe.sv
// Multi-lane masked G(4) multiplier with valid/ready on data and randomness.
// A single enable advances every lane so shares of one beat never split across stalls.
module msk_g4mul_hpc1_pipe
    import msk_g4mul_hpc1_pipe_pkg::*;
#(
    parameter int D       = 2,
    parameter int L       = 1,
    parameter int REFRESH = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [L*D-1:0]           ina0,
    input  logic [L*D-1:0]           ina1,
    input  logic [L*D-1:0]           inb0,
    input  logic [L*D-1:0]           inb1,
    input  logic [L*rnd_bits(D)-1:0] rnd,
    input  logic                     rnd_valid,
    output logic                     rnd_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [L*D-1:0]           out0,
    output logic [L*D-1:0]           out1
);

    localparam int R = rnd_bits(D);

    logic              en;
    logic [STAGES:1]   vld_pipe;

    // Advance only with fresh randomness and room at the output; bubbles still burn a rnd word.
    always_comb begin
        en        = rnd_valid && (out_ready || !vld_pipe[STAGES]);
        in_ready  = en;
        rnd_ready = en;
        out_valid = vld_pipe[STAGES];
    end

    // Valid shift register tracks beats alongside the lane share registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld_pipe <= '0;
        else if (en)
            vld_pipe <= {vld_pipe[1], in_valid};
    end

    for (genvar l = 0; l < L; l++) begin : g_lane
        msk_g4mul_lane #(
            .D       (D),
            .REFRESH (REFRESH)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .a0   (ina0[l*D +: D]),
            .a1   (ina1[l*D +: D]),
            .b0   (inb0[l*D +: D]),
            .b1   (inb1[l*D +: D]),
            .rnd  (rnd[l*R +: R]),
            .out0 (out0[l*D +: D]),
            .out1 (out1[l*D +: D])
        );
    end

endmodule

// File: tb/tb_msk_g4mul_hpc1_pipe.sv
// Directed bench: d=2, L=2; one HPC1 instance and one plain-DOM instance on the same stimulus.
module tb_msk_g4mul_hpc1_pipe;

    localparam int D = 2;
    localparam int L = 2;
    localparam int R = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid, rnd_valid, out_ready;
    logic [L*D-1:0] ina0, ina1, inb0, inb1;
    logic [L*R-1:0] rnd;

    logic           in_ready, rnd_ready, out_valid;
    logic [L*D-1:0] out0, out1;
    logic           in_ready_n, rnd_ready_n, out_valid_n;
    logic [L*D-1:0] out0_n, out1_n;

    logic [3:0]     snap0, snap1, snap0_n, snap1_n;

    int vectors = 0;
    int errs    = 0;

    // Hand-computed G(4) products, index a*4+b.
    int exp_tab [16] = '{0, 0, 0, 0,
                         0, 2, 3, 1,
                         0, 3, 1, 2,
                         0, 1, 2, 3};

    always #5 clk = ~clk;

    msk_g4mul_hpc1_pipe #(.D(D), .L(L), .REFRESH(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ina0(ina0), .ina1(ina1), .inb0(inb0), .inb1(inb1),
        .rnd(rnd), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out0(out0), .out1(out1)
    );

    msk_g4mul_hpc1_pipe #(.D(D), .L(L), .REFRESH(0)) dut_n (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n),
        .ina0(ina0), .ina1(ina1), .inb0(inb0), .inb1(inb1),
        .rnd(rnd), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready_n),
        .out_valid(out_valid_n), .out_ready(out_ready), .out0(out0_n), .out1(out1_n)
    );

    function automatic logic [3:0] unmask(input logic [3:0] o0, input logic [3:0] o1);
        return {^o1[3:2], ^o0[3:2], ^o1[1:0], ^o0[1:0]};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Fresh random sharings of lane0 (a,b) and lane1 (a,b), plus a fresh rnd word.
    task automatic beat(input logic v, input logic [1:0] a_l0, input logic [1:0] b_l0,
                        input logic [1:0] a_l1, input logic [1:0] b_l1);
        logic [1:0] m;
        logic [1:0] av [2];
        logic [1:0] bv [2];
        av[0] = a_l0; av[1] = a_l1;
        bv[0] = b_l0; bv[1] = b_l1;
        for (int l = 0; l < 2; l++) begin
            m = 2'($urandom);
            ina1[2*l] = m[1]; ina0[2*l] = m[0];
            ina1[2*l+1] = m[1] ^ av[l][1]; ina0[2*l+1] = m[0] ^ av[l][0];
            m = 2'($urandom);
            inb1[2*l] = m[1]; inb0[2*l] = m[0];
            inb1[2*l+1] = m[1] ^ bv[l][1]; inb0[2*l+1] = m[0] ^ bv[l][0];
        end
        in_valid = v;
        rnd = 8'($urandom);
    endtask

    task automatic check_out(input string tag, input logic ev, input logic [3:0] val);
        check({tag, ".vld"}, 8'(out_valid), 8'(ev));
        check({tag, ".vld_n"}, 8'(out_valid_n), 8'(ev));
        if (ev) begin
            check({tag, ".val"}, 8'(unmask(out0, out1)), 8'(val));
            check({tag, ".val_n"}, 8'(unmask(out0_n, out1_n)), 8'(val));
        end
    endtask

    task automatic check_hold(input string tag);
        check({tag, ".o0"}, 8'(out0), 8'(snap0));
        check({tag, ".o1"}, 8'(out1), 8'(snap1));
        check({tag, ".o0_n"}, 8'(out0_n), 8'(snap0_n));
        check({tag, ".o1_n"}, 8'(out1_n), 8'(snap1_n));
        check({tag, ".vld"}, 8'(out_valid), 8'd1);
        check({tag, ".in_rdy"}, 8'(in_ready), 8'd0);
        check({tag, ".rnd_rdy"}, 8'(rnd_ready), 8'd0);
        check({tag, ".in_rdy_n"}, 8'(in_ready_n), 8'd0);
    endtask

    task automatic take_snap();
        snap0 = out0; snap1 = out1; snap0_n = out0_n; snap1_n = out1_n;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; rnd_valid = 1'b1; out_ready = 1'b1;
        ina0 = '0; ina1 = '0; inb0 = '0; inb1 = '0; rnd = '0;

        // Reset state
        @(negedge clk); #1;
        check("rst.vld", 8'(out_valid), 8'd0);
        check("rst.out0", 8'(out0), 8'd0);
        check("rst.out1", 8'(out1), 8'd0);
        check("rst.out0_n", 8'(out0_n), 8'd0);
        @(negedge clk);
        rst = 1'b0; #1;
        check("rst.in_rdy", 8'(in_ready), 8'd1);

        // Single beat: lane0 10*11=10, lane1 11*11=11
        @(negedge clk); beat(1'b1, 2'b10, 2'b11, 2'b11, 2'b11); #1;
        check("single.in_rdy", 8'(in_ready), 8'd1);
        check("single.rnd_rdy", 8'(rnd_ready), 8'd1);
        @(negedge clk); beat(1'b0, 2'b00, 2'b00, 2'b00, 2'b00); #1;
        check_out("single.c1", 1'b0, 4'h0);
        @(negedge clk); #1;
        check_out("single.c2", 1'b1, 4'b1110);
        @(negedge clk); #1;
        check_out("single.c3", 1'b0, 4'h0);

        // Exhaustive back-to-back: lane0 index k, lane1 index 15-k
        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            if (k < 16)
                beat(1'b1, 2'(k >> 2), 2'(k), 2'((15 - k) >> 2), 2'(15 - k));
            else
                beat(1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
            #1;
            if (k >= 2 && k < 18)
                check_out($sformatf("exh%0d", k - 2), 1'b1,
                          {2'(exp_tab[17 - k]), 2'(exp_tab[k - 2])});
            else
                check_out($sformatf("exh.idle%0d", k), 1'b0, 4'h0);
        end

        // Backpressure: A = {01*10, 10*10} -> 0111, B -> 1011, C -> 1001
        @(negedge clk); beat(1'b1, 2'd1, 2'd2, 2'd2, 2'd2);
        @(negedge clk); beat(1'b1, 2'd2, 2'd1, 2'd1, 2'd1);
        @(negedge clk); beat(1'b1, 2'd3, 2'd1, 2'd2, 2'd3); out_ready = 1'b0; #1;
        check("bp.in_rdy", 8'(in_ready), 8'd0);
        check("bp.rnd_rdy", 8'(rnd_ready), 8'd0);
        check_out("bp.A0", 1'b1, 4'b0111);
        take_snap();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); rnd = 8'($urandom); #1;
            check_hold($sformatf("bp.hold%0d", c));
        end
        @(negedge clk); out_ready = 1'b1; #1;
        check("bp.rel_rdy", 8'(in_ready), 8'd1);
        check_out("bp.A", 1'b1, 4'b0111);
        @(negedge clk); beat(1'b0, 2'b00, 2'b00, 2'b00, 2'b00); #1;
        check_out("bp.B", 1'b1, 4'b1011);
        @(negedge clk); #1;
        check_out("bp.C", 1'b1, 4'b1001);
        @(negedge clk); #1;
        check_out("bp.end", 1'b0, 4'h0);

        // Randomness starvation: D1 -> 0010, D2 -> 1001, D3 -> 1101
        @(negedge clk); beat(1'b1, 2'd1, 2'd1, 2'd0, 2'd3);
        @(negedge clk); beat(1'b1, 2'd2, 2'd2, 2'd3, 2'd2);
        @(negedge clk); beat(1'b1, 2'd1, 2'd3, 2'd2, 2'd1); rnd_valid = 1'b0; #1;
        check("st.in_rdy", 8'(in_ready), 8'd0);
        check("st.rnd_rdy", 8'(rnd_ready), 8'd0);
        check_out("st.D1a", 1'b1, 4'b0010);
        take_snap();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); rnd = 8'($urandom); #1;
            check_hold($sformatf("st.hold%0d", c));
        end
        @(negedge clk); rnd_valid = 1'b1; #1;
        check("st.rel_rdy", 8'(in_ready), 8'd1);
        check_out("st.D1", 1'b1, 4'b0010);
        @(negedge clk); beat(1'b0, 2'b00, 2'b00, 2'b00, 2'b00); #1;
        check_out("st.D2", 1'b1, 4'b1001);
        @(negedge clk); #1;
        check_out("st.D3", 1'b1, 4'b1101);
        @(negedge clk); #1;
        check_out("st.end", 1'b0, 4'h0);

        // Reset mid-flight with both stages full; E1 -> 0110, F -> 1101
        @(negedge clk); beat(1'b1, 2'd3, 2'd2, 2'd1, 2'd3);
        @(negedge clk); beat(1'b1, 2'd1, 2'd1, 2'd2, 2'd2);
        @(negedge clk); beat(1'b1, 2'd2, 2'd3, 2'd3, 2'd1); #1;
        check_out("mr.E1", 1'b1, 4'b0110);
        rst = 1'b1; #1;
        check("mr.vld", 8'(out_valid), 8'd0);
        check("mr.out0", 8'(out0), 8'd0);
        check("mr.out1", 8'(out1), 8'd0);
        check("mr.vld_n", 8'(out_valid_n), 8'd0);
        check("mr.out0_n", 8'(out0_n), 8'd0);
        @(negedge clk); rst = 1'b0; beat(1'b1, 2'd2, 2'd2, 2'd1, 2'd2); #1;
        check("mr.in_rdy", 8'(in_ready), 8'd1);
        @(negedge clk); beat(1'b0, 2'b00, 2'b00, 2'b00, 2'b00); #1;
        check_out("mr.c1", 1'b0, 4'h0);
        @(negedge clk); #1;
        check_out("mr.F", 1'b1, 4'b1101);
        @(negedge clk); #1;
        check_out("mr.end", 1'b0, 4'h0);

        // Fixed sharings, all-zero rnd: share0 = a_s0*b_s0 ^ a_s0*b_s1 per lane
        @(negedge clk);
        in_valid = 1'b1; rnd = '0;
        ina1 = 4'b0110; ina0 = 4'b1011; inb1 = 4'b0101; inb0 = 4'b0110;
        @(negedge clk); in_valid = 1'b0; rnd = '0;
        @(negedge clk); #1;
        check_out("zr", 1'b1, 4'b1110);
        check("zr.share0_n", 8'({out1_n[2], out0_n[2], out1_n[0], out0_n[0]}), 8'b1001);
        check("zr.share0", 8'({out1[2], out0[2], out1[0], out0[0]}), 8'b1001);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/msk_g4mul_hpc1_pipe.md
Name: msk_g4mul_hpc1_pipe

Overview:
- Multi-lane, flow-controlled successor of the HPC1 masked G(4) multiplier.
- Per lane, an SNI refresh of operand b feeds a DOM-indep masked GF(2^2) multiply.
- Pipeline is 2 stages with valid/ready handshakes on data and randomness, so the S-box datapath can stall it without breaking share alignment.
- Sits in the masked inversion/S-box path and is also reusable for bitsliced multi-S-box configurations.

Parameters:
- d, 2, number of shares (d >= 2).
- L, 1, number of independent G(4) lanes.
- REFRESH, 1: 1 = SNI refresh of b (HPC1); 0 = b only registered (plain DOM; caller guarantees operand independence). Latency is identical in both modes.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  operand beat accepted when in_valid && in_ready.
- ina0, ina1  in  L*d each  sharings of a bit1/bit0; lane l share i at bit l*d+i.
- inb0, inb1  in  L*d each  sharings of b, same layout.
- rnd  in  L*R  fresh randomness; R = 2*REF_RND + 2*DOM_RND per lane.
- rnd_valid  in  1  rnd word valid.
- rnd_ready  out  1  rnd word consumed.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream ready.
- out0, out1  out  L*d each  sharings of the product, same layout.

Behaviour:
- Global enable: en = rnd_valid && (out_ready || !out_valid).
- in_ready = en; rnd_ready = en. Both are combinational; in_ready never depends on in_valid.
- One rnd word is consumed on every en cycle, bubbles included, so randomness is never reused.
- Stage 1 (loads on en):
  - v1 <= in_valid.
  - a registered unchanged.
  - b refreshed with the lane's rnd[REF part] when REFRESH = 1, else registered unchanged.
- Stage 2 (loads on en):
  - v2 <= v1.
  - DOM-indep multiply of stage-1 a and b using rnd[DOM part] of the same word.
  - Cross-domain terms are registered before compression.
  - Outputs are share-wise XOR of registered terms.
- out_valid = v2; out0/out1 are driven from stage-2 registers only, never combinational from inputs.
- Latency: exactly 2 en cycles from acceptance to out_valid. Throughput: 1 beat/cycle when unstalled.
- Unmasked function (Canright normal basis):
  - e = (a1^a0)&(b1^b0)
  - p1 = (a1&b1)^e
  - p0 = (a0&b0)^e
- Masked rule: XOR of all output shares equals p for every lane.
- Stall: when en = 0, all registers hold, including share registers (no share recombination or reload), and no rnd is consumed.
- Output backpressure: when out_valid && !out_ready, the output beat is held stable; in_ready = 0.
- Randomness starvation: when rnd_valid = 0, in_ready = 0 and the pipe freezes even if downstream is ready.
- Simultaneous accept and emit: allowed in the same cycle; there are no bubbles at full rate.
- Reset (async, any time, including mid-flight):
  - v1 = v2 = 0, out_valid = 0.
  - All share registers = 0, so out0 = out1 = 0.
  - In-flight beats are discarded.
  - After deassertion, in_ready follows en immediately.
- Lanes are fully independent; lane l uses only rnd[l*R +: R].

Decomposition:
- Shared header (msk_rnd_counts.vh):
  - REF_RND(d) = d*(d-1)/2 and DOM_RND(d) = d*(d-1)/2 as constant functions.
  - R(d) and the rnd bit-slice offsets: REF part at [0 +: 2*REF_RND], DOM part above it.
- Sub-module msk_g4mul_lane:
  - One lane's 2-stage datapath with an en input, no valid logic.
  - The top module holds the handshake/valid control and a generate loop over L.

Test Plan (d=2, L=2, random sharings, random rnd unless stated):
- Single beat: lane0 a=10, b=11; lane1 a=11, b=11; rnd_valid=1, out_ready=1 → out_valid 2 cycles after accept; unmasked lane0=10, lane1=11.
- Exhaustive: all 16 (a,b) pairs per lane streamed back-to-back → one result per cycle, each equal to the formula (e.g. a=01, b=01 → 10; a=11 is the identity), no bubbles.
- Backpressure: out_ready=0 for 5 cycles mid-stream → out0/out1/out_valid stable bit-for-bit, in_ready=0, rnd_ready=0; after release, order and values preserved.
- Randomness starvation: rnd_valid=0 for 3 cycles with in_valid=1 → in_ready=0, no state change; share-level registers identical before and after.
- Reset mid-flight: assert rst with v1=v2=1 → out_valid=0 and outputs=0 asynchronously; first beat after reset emerges alone with correct value.
- REFRESH=0 build: same vectors → same unmasked results and latency; all-zero rnd with d=2 → out share0 equals the unrefreshed DOM share0 computed by the reference model.
